ula_seq: RTL

ULA_SEQ -- requirements
Module: ula_seq

---
 rtl/ula_pkg.sv | 28 ++
 rtl/ula_seq_ula.sv | 72 +++++++
 rtl/ula_seq.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/ula_pkg.sv
// Shared definitions for ula and ula_seq: opcodes, flag bit positions and
// the sequencer state encoding.
package ula_pkg;

    localparam logic [4:0] OP_ADD = 5'd3;
    localparam logic [4:0] OP_SUB = 5'd4;
    localparam logic [4:0] OP_MUL = 5'd5;
    localparam logic [4:0] OP_DIV = 5'd6;
    localparam logic [4:0] OP_AND = 5'd7;

    localparam int FLG_EQUAL    = 0;
    localparam int FLG_ABOVE    = 1;
    localparam int FLG_BELOW    = 2;
    localparam int FLG_OVERFLOW = 3;
    localparam int FLG_ERROR    = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    function automatic logic is_muldiv(input logic [4:0] op);
        return (op == OP_MUL) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/ula_seq_ula.sv
// Combinational ula: unsigned 32-bit arithmetic/logic on a and b, opcode in
// inst[31:27]; compare flags always reflect a versus b.
module ula
    import ula_pkg::*;
(
    input  logic [31:0] inst,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] result,
    output logic [4:0]  flags
);

    logic [4:0]  op_s;
    logic [26:0] inst_unused_s;
    logic [32:0] sum_s;
    logic [63:0] prod_s;
    logic        err_s;
    logic        ovf_s;

    assign op_s          = inst[31:27];
    assign inst_unused_s = inst[26:0];
    assign sum_s         = {1'b0, a} + {1'b0, b};
    assign prod_s        = {32'd0, a} * {32'd0, b};

    // Result and error/overflow selection per opcode
    always_comb begin
        result = 32'd0;
        err_s  = 1'b0;
        ovf_s  = 1'b0;
        case (op_s)
            OP_ADD: begin
                result = sum_s[31:0];
                ovf_s  = sum_s[32];
            end
            OP_SUB: begin
                result = a - b;
                ovf_s  = (a < b);
            end
            OP_MUL: begin
                result = prod_s[31:0];
                ovf_s  = |prod_s[63:32];
            end
            OP_DIV: begin
                // Divide by zero reports error and a zero quotient
                if (b == 32'd0) begin
                    err_s  = 1'b1;
                    result = 32'd0;
                end else begin
                    err_s  = 1'b0;
                    result = a / b;
                end
            end
            OP_AND: begin
                result = a & b;
            end
            default: begin
                err_s = 1'b1;
            end
        endcase
    end

    // Flag vector assembly
    always_comb begin
        flags               = 5'd0;
        flags[FLG_ERROR]    = err_s;
        flags[FLG_OVERFLOW] = ovf_s;
        flags[FLG_BELOW]    = (a < b);
        flags[FLG_ABOVE]    = (a > b);
        flags[FLG_EQUAL]    = (a == b);
    end

endmodule

// File: rtl/ula_seq.sv
// Request/response sequencer around a single ula instance, with extra wait
// cycles for MUL/DIV. Optional sticky status under macro ULA_SEQ_STICKY_EN.
module ula_seq
    import ula_pkg::*;
#(
    parameter int MD_LAT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_inst,
    input  logic [31:0] in_a,
    input  logic [31:0] in_b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_result,
    output logic [4:0]  out_flags,
    input  logic        sticky_clr,
    output logic        sticky_ovf,
    output logic        sticky_err
);

    localparam bit         MD_EN   = (MD_LAT > 0);
    localparam logic [3:0] MD_LOAD = (MD_LAT > 0) ? 4'(MD_LAT - 1) : 4'd0;

    state_t      state_r;
    state_t      state_nx_s;
    logic [3:0]  cnt_r;
    logic [3:0]  cnt_nx_s;
    logic [31:0] inst_r;
    logic [31:0] a_r;
    logic [31:0] b_r;
    logic        accept_s;
    logic        capture_s;
    logic [31:0] ula_result_s;
    logic [4:0]  ula_flags_s;

    ula u_ula (
        .inst   (inst_r),
        .a      (a_r),
        .b      (b_r),
        .result (ula_result_s),
        .flags  (ula_flags_s)
    );

    assign in_ready = (state_r == ST_IDLE) && !rst;

    // Next-state, counter and capture/accept strobes
    always_comb begin
        state_nx_s = state_r;
        cnt_nx_s   = cnt_r;
        accept_s   = 1'b0;
        capture_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (in_valid) begin
                    accept_s   = 1'b1;
                    state_nx_s = ST_ISSUE;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (MD_EN && is_muldiv(inst_r[31:27])) begin
                    cnt_nx_s   = MD_LOAD;
                    state_nx_s = ST_WAIT;
                end else begin
                    capture_s  = 1'b1;
                    state_nx_s = ST_DONE;
                end
            end
            ST_WAIT: begin
                if (cnt_r == 4'd0) begin
                    capture_s  = 1'b1;
                    state_nx_s = ST_DONE;
                end else begin
                    cnt_nx_s   = cnt_r - 4'd1;
                    state_nx_s = ST_WAIT;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_nx_s = ST_IDLE;
                end else begin
                    state_nx_s = ST_DONE;
                end
            end
            default: begin
                state_nx_s = ST_IDLE;
            end
        endcase
    end

    // State, operand and result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            cnt_r      <= 4'd0;
            inst_r     <= 32'd0;
            a_r        <= 32'd0;
            b_r        <= 32'd0;
            out_valid  <= 1'b0;
            out_result <= 32'd0;
            out_flags  <= 5'd0;
        end else begin
            state_r   <= state_nx_s;
            cnt_r     <= cnt_nx_s;
            out_valid <= (state_nx_s == ST_DONE);
            if (accept_s) begin
                inst_r <= in_inst;
                a_r    <= in_a;
                b_r    <= in_b;
            end
            if (capture_s) begin
                out_result <= ula_result_s;
                out_flags  <= ula_flags_s;
            end
        end
    end

`ifdef ULA_SEQ_STICKY_EN
    // Sticky accumulation: a capture setting a flag beats a same-cycle clear
    always_ff @(posedge clk) begin
        if (rst) begin
            sticky_ovf <= 1'b0;
            sticky_err <= 1'b0;
        end else begin
            sticky_ovf <= (sticky_ovf && !sticky_clr) || (capture_s && ula_flags_s[FLG_OVERFLOW]);
            sticky_err <= (sticky_err && !sticky_clr) || (capture_s && ula_flags_s[FLG_ERROR]);
        end
    end
`else
    logic sticky_clr_unused_s;
    assign sticky_clr_unused_s = sticky_clr;
    assign sticky_ovf          = 1'b0;
    assign sticky_err          = 1'b0;
`endif

endmodule
